mp_regfile_sb: RTL

- Parametrised multi-port integer register file with an integrated busy-bit scoreboard for the dual-issue superscalar core.
- Provides NUM_RD combinational read ports and NUM_WR synchronous write ports, with same-cycle write-to-read bypass and x0 hard-wired to zero.
- Per-register pending bits are set at issue (allocate) and cleared at writeback; the decode stage uses them for RAW hazard stalls.
- Sits between decode/issue and the writeback stage; replaces the single-write, two-read file.

---
 rtl/mp_regfile_sb.sv | 103 ++++++++++
 1 files changed

// File: rtl/mp_regfile_sb.sv
// Multi-port register file with busy-bit scoreboard: combinational reads with same-cycle write bypass, x0 reads as zero.
// Writes, allocates and busy_cnt update on the rising edge; no back-pressure, every write and allocate is taken each cycle.
module mp_regfile_sb #(
   parameter int XLEN   = 32,
   parameter int NREGS  = 32,
   parameter int AW     = 5,
   parameter int NUM_RD = 4,
   parameter int NUM_WR = 2
) (
   input  logic                     clk,
   input  logic                     rst_n,
   input  logic [NUM_RD*AW-1:0]     ra,
   output logic [NUM_RD*XLEN-1:0]   rd_data,
   output logic [NUM_RD-1:0]        rd_busy,
   input  logic [NUM_WR-1:0]        we,
   input  logic [NUM_WR*AW-1:0]     wa,
   input  logic [NUM_WR*XLEN-1:0]   wd,
   input  logic [NUM_WR-1:0]        alloc_v,
   input  logic [NUM_WR*AW-1:0]     alloc_a,
   output logic [AW:0]              busy_cnt
);

   localparam int CW = AW + 1;

   logic [XLEN-1:0]  mem_q [NREGS];
   logic [XLEN-1:0]  mem_d [NREGS];
   logic [NREGS-1:0] busy_q;
   logic [NREGS-1:0] busy_d;
   logic [NREGS-1:0] clear;
   logic [NREGS-1:0] set;
   logic [CW-1:0]    busy_cnt_q;
   logic [CW-1:0]    busy_cnt_d;

   // Later write ports overwrite earlier ones, so the highest index wins on a collision.
   always_comb begin : mem_next
      mem_d = mem_q;
      for (int j = 0; j < NUM_WR; j++) begin
         if (we[j] && (wa[j*AW +: AW] != '0)) begin
            mem_d[wa[j*AW +: AW]] = wd[j*XLEN +: XLEN];
         end
      end
      mem_d[0] = '0;
   end

   always_comb begin : sb_next
      clear      = '0;
      set        = '0;
      busy_cnt_d = '0;
      for (int j = 0; j < NUM_WR; j++) begin
         if (we[j]) begin
            clear[wa[j*AW +: AW]] = 1'b1;
         end
         if (alloc_v[j]) begin
            set[alloc_a[j*AW +: AW]] = 1'b1;
         end
      end
      busy_d    = (busy_q & ~clear) | set;
      busy_d[0] = 1'b0;
      for (int r = 0; r < NREGS; r++) begin
         busy_cnt_d = busy_cnt_d + CW'(busy_d[r]);
      end
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         for (int r = 0; r < NREGS; r++) begin
            mem_q[r] <= '0;
         end
         busy_q     <= '0;
         busy_cnt_q <= '0;
      end else begin
         mem_q      <= mem_d;
         busy_q     <= busy_d;
         busy_cnt_q <= busy_cnt_d;
      end
   end

   assign busy_cnt = busy_cnt_q;

   for (genvar i = 0; i < NUM_RD; i++) begin : g_rd
      logic [AW-1:0]   rd_addr;
      logic [XLEN-1:0] rd_val;

      assign rd_addr = ra[i*AW +: AW];

      always_comb begin
         rd_val = mem_q[rd_addr];
         for (int j = 0; j < NUM_WR; j++) begin
            if (we[j] && (wa[j*AW +: AW] == rd_addr)) begin
               rd_val = wd[j*XLEN +: XLEN];
            end
         end
         if (rd_addr == '0) begin
            rd_val = '0;
         end
      end

      assign rd_data[i*XLEN +: XLEN] = rd_val;
      // A producer writing back this cycle is already visible through the bypass.
      assign rd_busy[i] = busy_q[rd_addr] & ~clear[rd_addr];
   end

endmodule
